// File: rtl/cpu_scoreboard_mc.sv
// rtl/cpu_scoreboard_mc.sv - multi-count register scoreboard with flush-cancellable allocations
// Optional macro SCOREBOARD_WB_BYPASS_EN: hazards see same-cycle writebacks as already retired.
module cpu_scoreboard_mc #(
    parameter int NUM_REGS    = 32,
    parameter int REG_BITS    = $clog2(NUM_REGS),
    parameter int NUM_WB      = 2,
    parameter int CNT_BITS    = 2,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         issue_valid,
    input  logic [REG_BITS-1:0]          issue_dest,
    output logic                         issue_full,
    input  logic                         chk_use_a,
    input  logic                         chk_use_b,
    input  logic                         chk_use_d,
    input  logic [REG_BITS-1:0]          chk_a,
    input  logic [REG_BITS-1:0]          chk_b,
    input  logic [REG_BITS-1:0]          chk_d,
    output logic                         hazard_a,
    output logic                         hazard_b,
    output logic                         hazard_d,
    output logic                         hazard,
    input  logic [NUM_WB-1:0]            wb_valid,
    input  logic [NUM_WB*REG_BITS-1:0]   wb_dest,
    input  logic                         flush,
    output logic [NUM_REGS-1:0]          busy_mask,
    output logic [REG_BITS+CNT_BITS-1:0] pending_total,
    output logic                         err_underflow
);

    localparam int W  = CNT_BITS + 2;
    localparam int TW = REG_BITS + CNT_BITS;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [CNT_BITS-1:0] count      [NUM_REGS];
    logic [CNT_BITS-1:0] next_count [NUM_REGS];
    logic [W-1:0]        wb_hits    [NUM_REGS];
    logic [W-1:0]        fl_hits    [NUM_REGS];
    logic [W-1:0]        diff       [NUM_REGS];

    logic                sh_valid [FLUSH_DEPTH];
    logic [REG_BITS-1:0] sh_dest  [FLUSH_DEPTH];

    logic                alloc;
    logic                underflow;
    logic [NUM_REGS-1:0] next_busy;
    logic [TW-1:0]       next_total;

    assign issue_full = (count[issue_dest] == CNT_MAX);
    assign alloc      = issue_valid && (issue_dest != '0) && !issue_full && !flush;

    // Hit counters: how many writeback ports and cancellable shadow entries name each register.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            wb_hits[r] = '0;
            fl_hits[r] = '0;
            if (r != 0) begin
                for (int p = 0; p < NUM_WB; p++) begin
                    if (wb_valid[p] && (wb_dest[p*REG_BITS +: REG_BITS] == REG_BITS'(r)))
                        wb_hits[r] = wb_hits[r] + W'(1);
                end
                for (int s = 0; s < FLUSH_DEPTH; s++) begin
                    if (flush && sh_valid[s] && (sh_dest[s] == REG_BITS'(r)))
                        fl_hits[r] = fl_hits[r] + W'(1);
                end
            end
        end
    end

    // Net update per register; the widened result's MSB flags a negative (underflow) outcome.
    always_comb begin
        underflow  = 1'b0;
        next_busy  = '0;
        next_total = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            diff[r]       = W'(count[r])
                          + W'(alloc && (issue_dest == REG_BITS'(r)))
                          - wb_hits[r] - fl_hits[r];
            next_count[r] = '0;
            if (r != 0) begin
                if (diff[r][W-1])
                    underflow = 1'b1;
                else
                    next_count[r] = diff[r][CNT_BITS-1:0];
            end
            next_busy[r] = (next_count[r] != '0);
            next_total   = next_total + TW'(next_count[r]);
        end
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    logic [W-1:0] avail_a, avail_b, avail_d;
    assign avail_a  = W'(count[chk_a]) - wb_hits[chk_a];
    assign avail_b  = W'(count[chk_b]) - wb_hits[chk_b];
    assign avail_d  = W'(count[chk_d]) - wb_hits[chk_d];
    assign hazard_a = chk_use_a && !avail_a[W-1] && (avail_a != '0);
    assign hazard_b = chk_use_b && !avail_b[W-1] && (avail_b != '0);
    assign hazard_d = chk_use_d && !avail_d[W-1] && (avail_d != '0);
`else
    assign hazard_a = chk_use_a && (count[chk_a] != '0);
    assign hazard_b = chk_use_b && (count[chk_b] != '0);
    assign hazard_d = chk_use_d && (count[chk_d] != '0);
`endif

    assign hazard = hazard_a || hazard_b || hazard_d || (issue_valid && issue_full);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                count[r] <= '0;
            busy_mask     <= '0;
            pending_total <= '0;
            err_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                count[r] <= next_count[r];
            busy_mask     <= next_busy;
            pending_total <= next_total;
            err_underflow <= err_underflow || underflow;
        end
    end

    // Shadow pipeline of recent allocations; a flush cancels them all and empties it.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int s = 0; s < FLUSH_DEPTH; s++) begin
                sh_valid[s] <= 1'b0;
                sh_dest[s]  <= '0;
            end
        end else begin
            sh_valid[0] <= alloc;
            sh_dest[0]  <= issue_dest;
            for (int s = 1; s < FLUSH_DEPTH; s++) begin
                sh_valid[s] <= sh_valid[s-1];
                sh_dest[s]  <= sh_dest[s-1];
            end
        end
    end

endmodule

// File: tb/tb_cpu_scoreboard_mc.sv
// tb/tb_cpu_scoreboard_mc.sv - directed self-checking bench for cpu_scoreboard_mc
module tb_cpu_scoreboard_mc;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_full;
    logic        chk_use_a, chk_use_b, chk_use_d;
    logic [4:0]  chk_a, chk_b, chk_d;
    logic        hazard_a, hazard_b, hazard_d, hazard;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_dest;
    logic        flush;
    logic [31:0] busy_mask;
    logic [6:0]  pending_total;
    logic        err_underflow;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    cpu_scoreboard_mc dut (
        .clock         (clock),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_dest    (issue_dest),
        .issue_full    (issue_full),
        .chk_use_a     (chk_use_a),
        .chk_use_b     (chk_use_b),
        .chk_use_d     (chk_use_d),
        .chk_a         (chk_a),
        .chk_b         (chk_b),
        .chk_d         (chk_d),
        .hazard_a      (hazard_a),
        .hazard_b      (hazard_b),
        .hazard_d      (hazard_d),
        .hazard        (hazard),
        .wb_valid      (wb_valid),
        .wb_dest       (wb_dest),
        .flush         (flush),
        .busy_mask     (busy_mask),
        .pending_total (pending_total),
        .err_underflow (err_underflow)
    );

    task automatic idle();
        issue_valid = 1'b0; issue_dest = '0;
        chk_use_a = 1'b0; chk_use_b = 1'b0; chk_use_d = 1'b0;
        chk_a = '0; chk_b = '0; chk_d = '0;
        wb_valid = '0; wb_dest = '0; flush = 1'b0;
    endtask

    // Advance one edge and settle; inputs then change away from the active edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        check("reset_busy", busy_mask, 32'h0);
        check("reset_total", 32'(pending_total), 0);
        check("reset_err", 32'(err_underflow), 0);
        reset = 1'b0;
        #2;
        check("reset_hazard", 32'(hazard), 0);

        // Load-use on r5
        issue_valid = 1'b1; issue_dest = 5'd5;
        #2; check("r5_full", 32'(issue_full), 0);
        tick();
        idle(); chk_use_a = 1'b1; chk_a = 5'd5;
        #2;
        check("r5_hazard_a", 32'(hazard_a), 1);
        check("r5_busy", 32'(busy_mask[5]), 1);
        check("r5_total", 32'(pending_total), 1);
        wb_valid = 2'b01; wb_dest = {5'd0, 5'd5};
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        check("r5_hazard_wb_cycle", 32'(hazard_a), 0);
`else
        check("r5_hazard_wb_cycle", 32'(hazard_a), 1);
`endif
        tick();
        wb_valid = '0;
        #1;
        check("r5_hazard_after", 32'(hazard_a), 0);
        check("r5_total_after", 32'(pending_total), 0);
        tick();

        // Saturate r7
        idle(); issue_valid = 1'b1; issue_dest = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1; check("r7_full_early", 32'(issue_full), 0);
            tick();
        end
        chk_use_d = 1'b1; chk_d = 5'd7; chk_b = 5'd7;
        #1;
        check("r7_full_sat", 32'(issue_full), 1);
        check("r7_hazard_sat", 32'(hazard), 1);
        check("r7_hazard_d", 32'(hazard_d), 1);
        check("r7_hazard_b_unused", 32'(hazard_b), 0);
        tick();
        idle();
        #1;
        check("r7_total_sat", 32'(pending_total), 3);
        check("r7_busy_sat", 32'(busy_mask[7]), 1);
        wb_valid = 2'b01; wb_dest = {5'd0, 5'd7};
        for (int i = 0; i < 3; i++) tick();
        idle();
        #1;
        check("r7_busy_drained", 32'(busy_mask[7]), 0);
        check("r7_total_drained", 32'(pending_total), 0);
        check("r7_no_err", 32'(err_underflow), 0);

        // Flush: r9 committed, r3/r4/r6 cancelled
        issue_valid = 1'b1; issue_dest = 5'd9; tick();
        idle(); tick();
        issue_valid = 1'b1; issue_dest = 5'd3; tick();
        issue_dest = 5'd4; tick();
        #1; check("pre_flush_total", 32'(pending_total), 3);
        issue_dest = 5'd6; flush = 1'b1;
        tick();
        idle();
        #1;
        check("flush_busy", busy_mask, 32'h0000_0200);
        check("flush_total", 32'(pending_total), 1);
        check("flush_no_err", 32'(err_underflow), 0);
        flush = 1'b1; tick();
        idle();
        #1; check("second_flush_total", 32'(pending_total), 1);
        wb_valid = 2'b10; wb_dest = {5'd9, 5'd0}; tick();
        idle();
        #1; check("r9_retired", 32'(pending_total), 0);

        // Same-cycle inc/dec cancel, and a double writeback
        issue_valid = 1'b1; issue_dest = 5'd8; tick();
        idle(); tick(); tick();
        issue_valid = 1'b1; issue_dest = 5'd8; wb_valid = 2'b01; wb_dest = {5'd0, 5'd8};
        tick();
        idle();
        #1;
        check("r8_net_zero", 32'(pending_total), 1);
        check("r8_busy", 32'(busy_mask[8]), 1);
        issue_valid = 1'b1; issue_dest = 5'd8; tick();
        idle();
        #1; check("r8_two", 32'(pending_total), 2);
        wb_valid = 2'b11; wb_dest = {5'd8, 5'd8}; tick();
        idle();
        #1;
        check("r8_double_wb", 32'(pending_total), 0);
        check("r8_double_no_err", 32'(err_underflow), 0);

        // Underflow is sticky; register 0 never tracked
        wb_valid = 2'b01; wb_dest = {5'd0, 5'd10}; tick();
        idle();
        #1;
        check("r10_underflow", 32'(err_underflow), 1);
        check("r10_total", 32'(pending_total), 0);
        tick(); tick();
        check("err_sticky", 32'(err_underflow), 1);
        issue_valid = 1'b1; issue_dest = 5'd0; chk_use_d = 1'b1; chk_d = 5'd0;
        #1;
        check("r0_full", 32'(issue_full), 0);
        check("r0_hazard", 32'(hazard), 0);
        tick();
        idle(); flush = 1'b1; wb_valid = 2'b11; wb_dest = {5'd0, 5'd0}; tick();
        idle();
        #1;
        check("r0_busy", busy_mask, 32'h0);
        check("r0_total", 32'(pending_total), 0);

        // Writeback vs. hazard in the same cycle on port 1
        issue_valid = 1'b1; issue_dest = 5'd2; tick();
        idle(); chk_use_b = 1'b1; chk_b = 5'd2;
        wb_valid = 2'b10; wb_dest = {5'd2, 5'd0};
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        check("r2_bypass_hazard_b", 32'(hazard_b), 0);
`else
        check("r2_bypass_hazard_b", 32'(hazard_b), 1);
`endif
        tick();
        idle();
        #1; check("r2_total", 32'(pending_total), 0);

        reset = 1'b1; tick();
        reset = 1'b0;
        check("reset_clears_err", 32'(err_underflow), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
